mmio_resume_ctrl: RTL and testbench
===================================

// Module: mmio_resume_ctrl
// PURPOSE
//   Responder side of the MMIO break/resume handshake.
//   - The core-side break generator raises irq_mmio and stalls the core.
//   - This block latches the pending MMIO access and forwards it to the host-side MMIO servicer.
//   - It waits for the host response, returns read data, then drives turn2run to release the stall.
//   - Sits between the core stall logic and the host MMIO bridge, all on one clock domain.
// PARAMETERS
//   ADDR_W         32            MMIO address width
//   DATA_W         32            MMIO data width
//   RESUME_CYCLES  4             cycles turn2run held high (>=3; covers receiver 2-flop delay)
//   TIMEOUT_CYCLES 1024          watchdog limit in WAIT_RSP (only with MMIO_TIMEOUT_EN)
//   ERR_RDATA      32'hDEADBEEF  rsp_rdata returned on timeout
// PORTS
//   clk            in   1       clock; all logic on posedge
//   reset          in   1       synchronous, active-high reset
//   irq_mmio       in   1       level; core stalled for MMIO
//   mmio_valid     in   1       pending MMIO access present this cycle
//   mmio_addr      in   ADDR_W  access address
//   mmio_wdata     in   DATA_W  write data
//   mmio_wen       in   1       1=write, 0=read
//   host_req_valid out  1       request to host servicer
//   host_req_ready in   1       host accepts request
//   host_req_addr  out  ADDR_W  latched address
//   host_req_wdata out  DATA_W  latched write data
//   host_req_wen   out  1       latched direction
//   host_rsp_valid in   1       host completion; required for reads and writes
//   host_rsp_rdata in   DATA_W  read data
//   rsp_rdata      out  DATA_W  data returned to core; held until next capture
//   turn2run       out  1       resume strobe to break generator
//   err            out  1       sticky: overrun or timeout
//   debug_state    out  3       current FSM state encoding
// BEHAVIOUR
//   Reset
//     - All outputs 0, state IDLE.
//     - Reset in any state aborts the transaction; no host response is awaited.
//   IDLE (0)
//     - irq_mmio & mmio_valid: latch addr/wdata/wen, go to ISSUE.
//     - irq_mmio without mmio_valid: stay in IDLE.
//   ISSUE (1)
//     - host_req_valid=1 with stable payload until host_req_ready.
//     - host_req_ready sampled high: drop valid next cycle, go to WAIT_RSP.
//     - host_rsp_valid in ISSUE (including the accept cycle) is ignored.
//   WAIT_RSP (2)
//     - On host_rsp_valid: rsp_rdata<=host_rsp_rdata for reads; unchanged for writes. Go to RESUME.
//   RESUME (3)
//     - turn2run=1 for exactly RESUME_CYCLES cycles via down-counter, then go to DRAIN.
//   DRAIN (4)
//     - turn2run=0; wait for irq_mmio low, then IDLE.
//     - Blocks re-capture of the same stall.
//   Overrun
//     - mmio_valid in any state other than IDLE sets err; the request is dropped.
//   Timing
//     - Minimum latency capture->turn2run rise = 3 cycles (ready and rsp each on first eligible cycle).
//   Width
//     - RESUME counter sized $clog2(RESUME_CYCLES+1); saturates at 0, no wrap.
// CONFIGURATION
//   MMIO_TIMEOUT_EN defined
//     - Watchdog counts cycles in WAIT_RSP.
//     - At TIMEOUT_CYCLES: rsp_rdata<=ERR_RDATA (reads), err<=1, go to RESUME.
//     - Late host_rsp_valid after timeout is ignored.
//   MMIO_TIMEOUT_EN undefined
//     - No counter; WAIT_RSP waits indefinitely.
// STRUCTURE
//   mmio_sync_pkg
//     - State encoding localparams (IDLE..DRAIN), default ERR_RDATA, state width 3.
//   Sub-module mmio_pulse_hold
//     - Loadable down-counter producing the RESUME_CYCLES-wide turn2run pulse.
//     - Reused for the watchdog when MMIO_TIMEOUT_EN is defined.
// TESTING
//   1. Read: irq_mmio=1, mmio_valid, addr=0x4000_0010, wen=0; ready 1st cycle; rsp rdata=0x1234_5678 2 cycles later
//      -> rsp_rdata=0x12345678; turn2run high 4 cycles; DRAIN until irq_mmio=0.
//   2. Write: wdata=0xA5A5_A5A5, wen=1; ready delayed 5 cycles
//      -> payload stable all 5; rsp_rdata unchanged; turn2run pulse of 4.
//   3. Overrun: mmio_valid pulse during WAIT_RSP
//      -> err=1 sticky; host sees exactly one request.
//   4. Reset asserted in WAIT_RSP
//      -> next cycle all outputs 0, debug_state=0; later host_rsp_valid ignored.
//   5. MMIO_TIMEOUT_EN, TIMEOUT_CYCLES=16, no response
//      -> after 16 cycles rsp_rdata=0xDEADBEEF, err=1, turn2run pulse.
//   6. irq_mmio held high after RESUME
//      -> stays in DRAIN, no second capture; returns to IDLE the cycle after irq_mmio falls.

Source files
------------

// File: rtl/mmio_sync_pkg.sv
// Shared state encoding and defaults for the MMIO break/resume responder.
package mmio_sync_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_RESUME   = 3'd3,
        ST_DRAIN    = 3'd4
    } state_e;

    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mmio_pulse_hold.sv
// Loadable saturating down-counter; last_c flags the final cycle of a loaded run.
module mmio_pulse_hold #(
    parameter int unsigned COUNT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic last_c
);

    localparam int unsigned CNT_W = $clog2(COUNT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(COUNT);
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign last_c = (count == CNT_W'(1));

endmodule

// File: rtl/mmio_resume_ctrl.sv
// Responder side of the MMIO break/resume handshake: capture, forward to host, resume core.
// Optional WAIT_RSP watchdog enabled by defining MMIO_TIMEOUT_EN.
module mmio_resume_ctrl
    import mmio_sync_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       RESUME_CYCLES  = 4,
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_RDATA      = DATA_W'(DEFAULT_ERR_RDATA)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               irq_mmio,
    input  logic               mmio_valid,
    input  logic [ADDR_W-1:0]  mmio_addr,
    input  logic [DATA_W-1:0]  mmio_wdata,
    input  logic               mmio_wen,
    output logic               host_req_valid,
    input  logic               host_req_ready,
    output logic [ADDR_W-1:0]  host_req_addr,
    output logic [DATA_W-1:0]  host_req_wdata,
    output logic               host_req_wen,
    input  logic               host_rsp_valid,
    input  logic [DATA_W-1:0]  host_rsp_rdata,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               turn2run,
    output logic               err,
    output logic [STATE_W-1:0] debug_state
);

    if (RESUME_CYCLES < 3) begin : g_bad_resume
        $error("RESUME_CYCLES must be at least 3");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    state_e state;
    state_e state_next;
    logic   capture;
    logic   accept;
    logic   finish;
    logic   timeout;
    logic   overrun;
    logic   resume_last_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (irq_mmio && mmio_valid) begin
                    capture    = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (host_req_ready) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (host_rsp_valid || timeout) begin
                    finish     = 1'b1;
                    state_next = ST_RESUME;
                end
            end
            ST_RESUME: begin
                if (resume_last_c) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Holding here until the stall drops stops the same stall being captured twice.
                if (!irq_mmio) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign overrun = mmio_valid && (state != ST_IDLE);

    mmio_pulse_hold #(
        .COUNT (RESUME_CYCLES)
    ) u_resume_hold (
        .clk    (clk),
        .reset  (reset),
        .load   (finish),
        .en     (state == ST_RESUME),
        .last_c (resume_last_c)
    );

`ifdef MMIO_TIMEOUT_EN
    logic wd_last_c;

    mmio_pulse_hold #(
        .COUNT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .en     (state == ST_WAIT_RSP),
        .last_c (wd_last_c)
    );

    // A response arriving on the final watchdog cycle still counts as on time.
    assign timeout = (state == ST_WAIT_RSP) && wd_last_c && !host_rsp_valid;
`else
    assign timeout = 1'b0;
`endif

    // Registered outputs follow the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            host_req_valid <= 1'b0;
            host_req_addr  <= '0;
            host_req_wdata <= '0;
            host_req_wen   <= 1'b0;
            rsp_rdata      <= '0;
            turn2run       <= 1'b0;
            err            <= 1'b0;
        end else begin
            if (capture) begin
                host_req_addr  <= mmio_addr;
                host_req_wdata <= mmio_wdata;
                host_req_wen   <= mmio_wen;
            end
            host_req_valid <= (state_next == ST_ISSUE);
            turn2run       <= (state_next == ST_RESUME);
            if (finish && !host_req_wen) begin
                rsp_rdata <= host_rsp_valid ? host_rsp_rdata : ERR_RDATA;
            end
            if (overrun || timeout) begin
                err <= 1'b1;
            end
        end
    end

    assign debug_state = state;

endmodule

// File: tb/tb_mmio_resume_ctrl.sv
// Scoreboard bench for mmio_resume_ctrl: driver pushes expectations, negedge monitor checks.
// Timeout scenario runs only when MMIO_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mmio_resume_ctrl;
    import mmio_sync_pkg::*;

    localparam int unsigned RESUME_CYCLES  = 4;
    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam logic [31:0] ERR_RDATA      = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq_mmio;
    logic        mmio_valid;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic        mmio_wen;
    logic        host_req_valid;
    logic        host_req_ready;
    logic [31:0] host_req_addr;
    logic [31:0] host_req_wdata;
    logic        host_req_wen;
    logic        host_rsp_valid;
    logic [31:0] host_rsp_rdata;
    logic [31:0] rsp_rdata;
    logic        turn2run;
    logic        err;
    logic [2:0]  debug_state;

    mmio_resume_ctrl #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .RESUME_CYCLES  (RESUME_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ERR_RDATA      (ERR_RDATA)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .irq_mmio       (irq_mmio),
        .mmio_valid     (mmio_valid),
        .mmio_addr      (mmio_addr),
        .mmio_wdata     (mmio_wdata),
        .mmio_wen       (mmio_wen),
        .host_req_valid (host_req_valid),
        .host_req_ready (host_req_ready),
        .host_req_addr  (host_req_addr),
        .host_req_wdata (host_req_wdata),
        .host_req_wen   (host_req_wen),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_rdata (host_rsp_rdata),
        .rsp_rdata      (rsp_rdata),
        .turn2run       (turn2run),
        .err            (err),
        .debug_state    (debug_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } res_t;

    req_t        req_q[$];
    res_t        res_q[$];
    res_t        mon_res;
    int unsigned checks     = 0;
    int unsigned passed     = 0;
    int unsigned handshakes = 0;
    int unsigned reqs_sent  = 0;
    int unsigned pulse_len  = 0;
    logic        t2r_prev   = 1'b0;
    logic [31:0] exp_rdata  = '0;
    logic        exp_err    = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: request payload stability/handshakes and resume pulses.
    always @(negedge clk) begin
        if (reset) begin
            t2r_prev  = 1'b0;
            pulse_len = 0;
        end else begin
            if (host_req_valid) begin
                chk("req_expected", 32'(req_q.size() != 0), 32'd1);
                if (req_q.size() != 0) begin
                    chk("req_addr", host_req_addr, req_q[0].addr);
                    chk("req_wdata", host_req_wdata, req_q[0].wdata);
                    chk("req_wen", 32'(host_req_wen), 32'(req_q[0].wen));
                    if (host_req_ready) begin
                        void'(req_q.pop_front());
                        handshakes++;
                    end
                end
            end
            if (turn2run && !t2r_prev) begin
                chk("resume_expected", 32'(res_q.size() != 0), 32'd1);
                if (res_q.size() != 0) begin
                    mon_res = res_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, mon_res.rdata);
                    chk("err_at_resume", 32'(err), 32'(mon_res.err));
                end
                pulse_len = 1;
            end else if (turn2run) begin
                pulse_len++;
            end else if (t2r_prev) begin
                chk("pulse_len", pulse_len, RESUME_CYCLES);
            end
            t2r_prev = turn2run;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic wen,
                           input int rd, input int rs, input logic [31:0] rdata,
                           input int hold, input bit ovr, input bit noise, input bit to);
        req_t r;
        res_t e;
        tick();
        irq_mmio   = 1'b1;
        mmio_valid = 1'b1;
        mmio_addr  = addr;
        mmio_wdata = wdata;
        mmio_wen   = wen;
        r = '{addr: addr, wdata: wdata, wen: wen};
        req_q.push_back(r);
        reqs_sent++;
        tick();
        mmio_valid = 1'b0;
        mmio_addr  = $urandom;
        mmio_wdata = $urandom;
        mmio_wen   = 1'($urandom_range(1));
        chk("state_issue", 32'(debug_state), 32'(ST_ISSUE));
        for (int i = 0; i <= rd; i++) begin
            host_req_ready = (i == rd);
            host_rsp_valid = noise & 1'($urandom_range(1));
            host_rsp_rdata = $urandom;
            tick();
        end
        host_req_ready = 1'b0;
        host_rsp_valid = 1'b0;
        chk("state_wait", 32'(debug_state), 32'(ST_WAIT_RSP));
        if (to) begin
            repeat (TIMEOUT_CYCLES - 1) tick();
            exp_err = 1'b1;
            if (!wen) exp_rdata = ERR_RDATA;
            e = '{rdata: exp_rdata, err: exp_err};
            res_q.push_back(e);
            chk("t2r_low_before_timeout", 32'(turn2run), 32'd0);
            tick();
        end else begin
            for (int i = 0; i < rs; i++) begin
                mmio_valid = ovr && (i == 0);
                tick();
            end
            mmio_valid = 1'b0;
            if (ovr && rs > 0) exp_err = 1'b1;
            if (!wen) exp_rdata = rdata;
            e = '{rdata: exp_rdata, err: exp_err};
            res_q.push_back(e);
            chk("t2r_low_before_rsp", 32'(turn2run), 32'd0);
            host_rsp_valid = 1'b1;
            host_rsp_rdata = rdata;
            tick();
            host_rsp_valid = 1'b0;
        end
        chk("t2r_rise_cycle", 32'(turn2run), 32'd1);
        chk("state_resume", 32'(debug_state), 32'(ST_RESUME));
        for (int i = 0; i < int'(RESUME_CYCLES); i++) begin
            host_rsp_valid = to | (noise & 1'($urandom_range(1)));
            host_rsp_rdata = $urandom;
            tick();
        end
        host_rsp_valid = 1'b0;
        chk("state_drain", 32'(debug_state), 32'(ST_DRAIN));
        chk("t2r_low_drain", 32'(turn2run), 32'd0);
        repeat (hold) tick();
        chk("drain_held", 32'(debug_state), 32'(ST_DRAIN));
        irq_mmio = 1'b0;
        tick();
        chk("state_idle", 32'(debug_state), 32'(ST_IDLE));
        chk("rsp_rdata_held", rsp_rdata, exp_rdata);
        chk("err_sticky", 32'(err), 32'(exp_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(host_req_valid), 32'd0);
        chk({tag, "_req_addr"}, host_req_addr, 32'd0);
        chk({tag, "_req_wdata"}, host_req_wdata, 32'd0);
        chk({tag, "_req_wen"}, 32'(host_req_wen), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_turn2run"}, 32'(turn2run), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_state"}, 32'(debug_state), 32'(ST_IDLE));
    endtask

    task automatic run_reset_in_wait();
        req_t r;
        tick();
        irq_mmio   = 1'b1;
        mmio_valid = 1'b1;
        mmio_addr  = 32'h4000_0020;
        mmio_wdata = 32'h0;
        mmio_wen   = 1'b0;
        r = '{addr: 32'h4000_0020, wdata: 32'h0, wen: 1'b0};
        req_q.push_back(r);
        reqs_sent++;
        tick();
        mmio_valid     = 1'b0;
        host_req_ready = 1'b1;
        tick();
        host_req_ready = 1'b0;
        chk("rst_pre_wait", 32'(debug_state), 32'(ST_WAIT_RSP));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_rdata = '0;
        exp_err   = 1'b0;
        check_reset_outputs("rst_wait");
        host_rsp_valid = 1'b1;
        host_rsp_rdata = 32'hCAFE_F00D;
        tick();
        host_rsp_valid = 1'b0;
        repeat (RESUME_CYCLES) begin
            chk("rst_late_rsp_state", 32'(debug_state), 32'(ST_IDLE));
            chk("rst_late_rsp_t2r", 32'(turn2run), 32'd0);
            tick();
        end
        chk("rst_late_rsp_rdata", rsp_rdata, 32'd0);
        irq_mmio = 1'b0;
    endtask

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_wen;

    initial begin
        reset          = 1'b1;
        irq_mmio       = 1'b0;
        mmio_valid     = 1'b0;
        mmio_addr      = '0;
        mmio_wdata     = '0;
        mmio_wen       = 1'b0;
        host_req_ready = 1'b0;
        host_rsp_valid = 1'b0;
        host_rsp_rdata = '0;
        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b0;
        tick();

        // Read, write with slow ready, minimum latency, long DRAIN hold.
        run_txn(32'h4000_0010, 32'h0, 1'b0, 0, 2, 32'h1234_5678, 0, 1'b0, 1'b0, 1'b0);
        run_txn(32'h4000_0014, 32'hA5A5_A5A5, 1'b1, 5, 1, 32'hFFFF_0000, 1, 1'b0, 1'b0, 1'b0);
        run_txn(32'h4000_0018, 32'h0, 1'b0, 0, 0, 32'h0BAD_C0DE, 0, 1'b0, 1'b1, 1'b0);
        run_txn(32'h4000_001C, 32'h0, 1'b0, 1, 1, 32'h5555_AAAA, 5, 1'b0, 1'b0, 1'b0);
        // Overrun pulse during WAIT_RSP, then reset aborting a transaction.
        run_txn(32'h4000_0030, 32'h0, 1'b0, 0, 3, 32'h7777_1111, 0, 1'b1, 1'b0, 1'b0);
        run_reset_in_wait();

        for (int n = 0; n < 40; n++) begin
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_rdata = $urandom;
            r_wen   = 1'($urandom_range(1));
            run_txn(r_addr, r_wdata, r_wen, int'($urandom_range(6)), int'($urandom_range(6)),
                    r_rdata, int'($urandom_range(3)), ($urandom_range(7) == 0),
                    1'($urandom_range(1)), 1'b0);
        end

`ifdef MMIO_TIMEOUT_EN
        run_txn(32'h4000_0040, 32'h0, 1'b0, 0, 0, 32'h0, 0, 1'b0, 1'b0, 1'b1);
        run_txn(32'h4000_0044, 32'h0, 1'b0, 0, 1, 32'h2468_ACE0, 0, 1'b0, 1'b0, 1'b0);
`endif

        repeat (3) tick();
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        chk("res_queue_drained", 32'(res_q.size()), 32'd0);
        chk("handshake_count", handshakes, reqs_sent);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
